wb_port_ctrl: RTL

//  Writeback-port controller. Shares the single register-file write port between
//  the execute path (ALU result, link PC+4) and the load path, whose memory

---
 rtl/wb_port_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/wb_port_ctrl.sv
// wb_port_ctrl
//   Arbitrates the single register-file write port between the execute path
//   (ALU result or link PC+4) and the load path. The load path's data arrives a
//   variable number of cycles after issue. One load may be outstanding. Execute
//   writes to the load's destination register are held off so they cannot land
//   before the older load (WAW ordering).
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   exe_valid/exe_sel/exe_rd/exe_ready
//                   execute writeback request. Handshake: the request transfers
//                   in the cycle where exe_valid && exe_ready. exe_ready is
//                   combinational and does not look at exe_valid. The requester
//                   holds its request until it is accepted.
//   ld_issue/ld_rd  load issued this cycle and its destination register
//   ld_busy         a load is outstanding (FSM in LD_PEND); ld_issue ignored
//   mem_rsp_valid   load data valid this cycle
//   rf_we/rf_waddr/wb_sel
//                   registered register-file write controls
//                   (wb_sel: 0=ALU, 1=mem, 2/3=PC+4)
//   ld_timeout_err  one-cycle pulse when an outstanding load is abandoned
module wb_port_ctrl #(
  parameter int LD_TIMEOUT = 15,
  parameter int RA_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exe_valid,
  input  logic [1:0]      exe_sel,
  input  logic [RA_W-1:0] exe_rd,
  output logic            exe_ready,
  input  logic            ld_issue,
  input  logic [RA_W-1:0] ld_rd,
  output logic            ld_busy,
  input  logic            mem_rsp_valid,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [1:0]      wb_sel,
  output logic            ld_timeout_err
);

  // The timer only has to reach LD_TIMEOUT-1.
  localparam int TW = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LD_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    LD_PEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [RA_W-1:0] pend_rd_q, pend_rd_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            rsp_take;
  logic            timeout_hit;
  logic            exe_fire;

  // ld_busy is the FSM state made visible; it doubles as the state debug view.
  assign ld_busy = (state_q == LD_PEND);

  // The load response owns the port in its cycle. An execute write to the
  // pending load's register would overtake it, so it waits (rd 0 is never
  // written and therefore never conflicts).
  assign exe_ready = !rst
                     && !(ld_busy && mem_rsp_valid)
                     && !(ld_busy && (pend_rd_q != '0) && (exe_rd == pend_rd_q));

  assign exe_fire = exe_valid && exe_ready;

  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    timer_d     = timer_q;
    rsp_take    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_issue) begin
          pend_rd_d = ld_rd;
          timer_d   = '0;
          state_d   = LD_PEND;
        end
      end
      LD_PEND: begin
        if (mem_rsp_valid) begin
          rsp_take = 1'b1;
          state_d  = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pend_rd_q      <= '0;
      timer_q        <= '0;
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      wb_sel         <= 2'd0;
      ld_timeout_err <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_rd_q      <= pend_rd_d;
      timer_q        <= timer_d;
      ld_timeout_err <= timeout_hit;
      rf_we          <= 1'b0;
      // rsp_take and exe_fire are exclusive because exe_ready drops on a response.
      if (rsp_take) begin
        rf_we    <= (pend_rd_q != '0);
        rf_waddr <= pend_rd_q;
        wb_sel   <= 2'd1;
      end else if (exe_fire) begin
        rf_we    <= (exe_rd != '0);
        rf_waddr <= exe_rd;
        wb_sel   <= exe_sel;
      end
    end
  end

endmodule
